// File: rtl/prog_wait_timer_if.sv
// Control/status bundle for prog_wait_timer: start/abort/mode/threshold in, status and wave out.
interface prog_wait_timer_if #(
    parameter int CNT_W = 24
);
    logic             i_start;
    logic             i_abort;
    logic [1:0]       i_mode;
    logic [CNT_W-1:0] i_threshold;
    logic             o_busy;
    logic             o_tick;
    logic             o_done;
    logic             o_wave;
    logic [CNT_W-1:0] o_count;
    logic             dbg_state;

    modport master (
        output i_start, i_abort, i_mode, i_threshold,
        input  o_busy, o_tick, o_done, o_wave, o_count, dbg_state
    );

    modport slave (
        input  i_start, i_abort, i_mode, i_threshold,
        output o_busy, o_tick, o_done, o_wave, o_count, dbg_state
    );
endinterface

// File: rtl/prog_wait_timer.sv
// Run-time programmable wait/period timer with prescaler and one-shot, periodic and toggle modes.
module prog_wait_timer #(
    parameter int CNT_W      = 24,
    parameter int PRESCALE   = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_n_reset,
    prog_wait_timer_if.slave  bus
);

    // Handshake: i_start and i_abort are level-sampled on every rising edge, no ready
    // back-pressure. Abort wins over start; a start in any state (re)loads mode and
    // threshold and restarts from zero. Results appear one cycle after the deciding edge.

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    localparam logic [1:0] MODE_PERIODIC = 2'd1;
    localparam logic [1:0] MODE_TOGGLE   = 2'd2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [PW-1:0]    pre;
    logic [CNT_W-1:0] thr;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             tick;
    logic             done;
    logic             wave;

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state <= S_IDLE;
            pre   <= '0;
            thr   <= '0;
            mode  <= '0;
            count <= '0;
            busy  <= 1'b0;
            tick  <= 1'b0;
            done  <= 1'b0;
            wave  <= IDLE_LEVEL;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (bus.i_abort) begin
                state <= S_IDLE;
                count <= '0;
                pre   <= '0;
                busy  <= 1'b0;
                wave  <= IDLE_LEVEL;
            end else if (bus.i_start) begin
                thr   <= bus.i_threshold;
                mode  <= bus.i_mode;
                count <= '0;
                pre   <= '0;
                wave  <= IDLE_LEVEL;
                if (bus.i_threshold != '0) begin
                    state <= S_RUN;
                    busy  <= 1'b1;
                end else begin
                    // A zero-length wait completes immediately regardless of mode.
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    tick  <= 1'b1;
                    done  <= 1'b1;
                end
            end else if (state == S_RUN) begin
                if (pre == PRE_MAX) begin
                    pre <= '0;
                    if (count == thr - 1'b1) begin
                        count <= '0;
                        tick  <= 1'b1;
                        case (mode)
                            MODE_PERIODIC: ;
                            MODE_TOGGLE:   wave <= ~wave;
                            default: begin
                                // One-shot, and the reserved encoding behaves the same.
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        endcase
                    end else begin
                        count <= count + 1'b1;
                    end
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

    assign bus.o_busy    = busy;
    assign bus.o_tick    = tick;
    assign bus.o_done    = done;
    assign bus.o_wave    = wave;
    assign bus.o_count   = count;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_prog_wait_timer.sv
// Directed bench for prog_wait_timer: three instances cover P=1/IDLE 0, P=4 and IDLE_LEVEL=1.
module tb_prog_wait_timer;

    localparam int CNT_W = 24;

    logic i_clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    prog_wait_timer_if #(.CNT_W(CNT_W)) bus_a ();
    prog_wait_timer_if #(.CNT_W(CNT_W)) bus_b ();
    prog_wait_timer_if #(.CNT_W(CNT_W)) bus_c ();

    prog_wait_timer #(.CNT_W(CNT_W), .PRESCALE(1), .IDLE_LEVEL(1'b0)) dut_a (
        .i_clk(i_clk), .i_n_reset(rst_n), .bus(bus_a.slave));
    prog_wait_timer #(.CNT_W(CNT_W), .PRESCALE(4), .IDLE_LEVEL(1'b0)) dut_b (
        .i_clk(i_clk), .i_n_reset(rst_n), .bus(bus_b.slave));
    prog_wait_timer #(.CNT_W(CNT_W), .PRESCALE(1), .IDLE_LEVEL(1'b1)) dut_c (
        .i_clk(i_clk), .i_n_reset(rst_n), .bus(bus_c.slave));

    // Clock and reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1ns after the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic busy, input logic tick,
                         input logic done, input logic [CNT_W-1:0] cnt);
        chk({tag, ".busy"}, 32'(bus_a.o_busy), 32'(busy));
        chk({tag, ".tick"}, 32'(bus_a.o_tick), 32'(tick));
        chk({tag, ".done"}, 32'(bus_a.o_done), 32'(done));
        chk({tag, ".count"}, 32'(bus_a.o_count), 32'(cnt));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_a.i_start = 0; bus_a.i_abort = 0; bus_a.i_mode = 0; bus_a.i_threshold = 0;
        bus_b.i_start = 0; bus_b.i_abort = 0; bus_b.i_mode = 0; bus_b.i_threshold = 0;
        bus_c.i_start = 0; bus_c.i_abort = 0; bus_c.i_mode = 0; bus_c.i_threshold = 0;

        // Reset values
        #12;
        chk_a("rst_a", 1'b0, 1'b0, 1'b0, '0);
        chk("rst_a.wave", 32'(bus_a.o_wave), 32'd0);
        chk("rst_a.state", 32'(bus_a.dbg_state), 32'd0);
        chk("rst_c.wave", 32'(bus_c.o_wave), 32'd1);
        chk("rst_b.busy", 32'(bus_b.o_busy), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Asynchronous reset in the middle of a periodic thr=10 run
        bus_a.i_start = 1; bus_a.i_mode = 2'd1; bus_a.i_threshold = 24'd10;
        cyc(1);
        bus_a.i_start = 0;
        chk_a("arst_run0", 1'b1, 1'b0, 1'b0, 24'd0);
        cyc(3);
        chk_a("arst_run3", 1'b1, 1'b0, 1'b0, 24'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("arst_now", 1'b0, 1'b0, 1'b0, 24'd0);
        chk("arst_now.wave", 32'(bus_a.o_wave), 32'd0);
        chk("arst_now.state", 32'(bus_a.dbg_state), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int e = 0; e < 14; e++) begin
            cyc(1);
            chk_a($sformatf("arst_after%0d", e), 1'b0, 1'b0, 1'b0, 24'd0);
        end

        // One-shot thr=5; threshold change after the start is ignored
        bus_a.i_start = 1; bus_a.i_mode = 2'd0; bus_a.i_threshold = 24'd5;
        cyc(1);
        bus_a.i_start = 0; bus_a.i_threshold = 24'd7;
        chk_a("os_e0", 1'b1, 1'b0, 1'b0, 24'd0);
        for (int e = 1; e <= 4; e++) begin
            cyc(1);
            chk_a($sformatf("os_e%0d", e), 1'b1, 1'b0, 1'b0, 24'(e));
        end
        cyc(1);
        chk_a("os_e5", 1'b0, 1'b1, 1'b1, 24'd0);
        chk("os_e5.state", 32'(bus_a.dbg_state), 32'd0);
        cyc(1);
        chk_a("os_e6", 1'b0, 1'b0, 1'b0, 24'd0);

        // Periodic thr=3 with P=4, aborted at edge 30
        bus_b.i_start = 1; bus_b.i_mode = 2'd1; bus_b.i_threshold = 24'd3;
        cyc(1);
        bus_b.i_start = 0;
        for (int e = 1; e <= 40; e++) begin
            cyc(1);
            if (e < 30) begin
                chk($sformatf("per_e%0d.tick", e), 32'(bus_b.o_tick), 32'(e % 12 == 0));
                chk($sformatf("per_e%0d.busy", e), 32'(bus_b.o_busy), 32'd1);
                chk($sformatf("per_e%0d.count", e), 32'(bus_b.o_count), 32'((e / 4) % 3));
            end else begin
                chk($sformatf("per_e%0d.tick", e), 32'(bus_b.o_tick), 32'd0);
                chk($sformatf("per_e%0d.busy", e), 32'(bus_b.o_busy), 32'd0);
                chk($sformatf("per_e%0d.count", e), 32'(bus_b.o_count), 32'd0);
            end
            chk($sformatf("per_e%0d.done", e), 32'(bus_b.o_done), 32'd0);
            bus_b.i_abort = (e == 29);
        end

        // Toggle thr=2 with IDLE_LEVEL=1; abort lands on an expiry edge
        bus_c.i_start = 1; bus_c.i_mode = 2'd2; bus_c.i_threshold = 24'd2;
        cyc(1);
        bus_c.i_start = 0;
        chk("tog_e0.wave", 32'(bus_c.o_wave), 32'd1);
        for (int e = 1; e <= 7; e++) begin
            cyc(1);
            chk($sformatf("tog_e%0d.wave", e), 32'(bus_c.o_wave), 32'(((e / 2) % 2) == 0));
            chk($sformatf("tog_e%0d.tick", e), 32'(bus_c.o_tick), 32'(e % 2 == 0));
            chk($sformatf("tog_e%0d.done", e), 32'(bus_c.o_done), 32'd0);
        end
        bus_c.i_abort = 1;
        cyc(1);
        bus_c.i_abort = 0;
        chk("tog_abort.wave", 32'(bus_c.o_wave), 32'd1);
        chk("tog_abort.tick", 32'(bus_c.o_tick), 32'd0);
        chk("tog_abort.busy", 32'(bus_c.o_busy), 32'd0);
        cyc(2);
        chk("tog_idle.tick", 32'(bus_c.o_tick), 32'd0);
        chk("tog_idle.wave", 32'(bus_c.o_wave), 32'd1);

        // Zero threshold: single pulse, never busy, even in periodic mode
        bus_a.i_start = 1; bus_a.i_mode = 2'd1; bus_a.i_threshold = 24'd0;
        cyc(1);
        bus_a.i_start = 0;
        chk_a("zero_e0", 1'b0, 1'b1, 1'b1, 24'd0);
        cyc(1);
        chk_a("zero_e1", 1'b0, 1'b0, 1'b0, 24'd0);
        cyc(1);
        chk_a("zero_e2", 1'b0, 1'b0, 1'b0, 24'd0);

        // Start and abort together at an expiry edge of a periodic thr=3 run
        bus_a.i_start = 1; bus_a.i_mode = 2'd1; bus_a.i_threshold = 24'd3;
        cyc(1);
        bus_a.i_start = 0;
        cyc(2);
        chk_a("cont_e2", 1'b1, 1'b0, 1'b0, 24'd2);
        bus_a.i_start = 1; bus_a.i_abort = 1;
        cyc(1);
        bus_a.i_start = 0; bus_a.i_abort = 0;
        chk_a("cont_e3", 1'b0, 1'b0, 1'b0, 24'd0);
        cyc(1);
        chk_a("cont_e4", 1'b0, 1'b0, 1'b0, 24'd0);

        // Restart: periodic thr=8 reloaded with thr=3 at count 5
        bus_a.i_start = 1; bus_a.i_mode = 2'd1; bus_a.i_threshold = 24'd8;
        cyc(1);
        bus_a.i_start = 0;
        cyc(5);
        chk_a("rs_e5", 1'b1, 1'b0, 1'b0, 24'd5);
        bus_a.i_start = 1; bus_a.i_threshold = 24'd3;
        cyc(1);
        bus_a.i_start = 0;
        chk_a("rs_e6", 1'b1, 1'b0, 1'b0, 24'd0);
        for (int e = 7; e <= 15; e++) begin
            cyc(1);
            chk_a($sformatf("rs_e%0d", e), 1'b1, 1'((e - 6) % 3 == 0), 1'b0, 24'((e - 6) % 3));
        end
        bus_a.i_abort = 1;
        cyc(1);
        bus_a.i_abort = 0;
        chk_a("rs_abort", 1'b0, 1'b0, 1'b0, 24'd0);

        // Periodic thr=1 at P=1 ticks on every cycle
        bus_a.i_start = 1; bus_a.i_mode = 2'd1; bus_a.i_threshold = 24'd1;
        cyc(1);
        bus_a.i_start = 0;
        chk_a("p1_e0", 1'b1, 1'b0, 1'b0, 24'd0);
        for (int e = 1; e <= 4; e++) begin
            cyc(1);
            chk_a($sformatf("p1_e%0d", e), 1'b1, 1'b1, 1'b0, 24'd0);
        end
        bus_a.i_abort = 1;
        cyc(1);
        bus_a.i_abort = 0;
        chk_a("p1_abort", 1'b0, 1'b0, 1'b0, 24'd0);

        // Reserved mode 3 behaves as one-shot
        bus_a.i_start = 1; bus_a.i_mode = 2'd3; bus_a.i_threshold = 24'd2;
        cyc(1);
        bus_a.i_start = 0;
        cyc(1);
        chk_a("m3_e1", 1'b1, 1'b0, 1'b0, 24'd1);
        cyc(1);
        chk_a("m3_e2", 1'b0, 1'b1, 1'b1, 24'd0);
        cyc(1);
        chk_a("m3_e3", 1'b0, 1'b0, 1'b0, 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_wait_timer.md
Name: prog_wait_timer

Overview:
- Run-time programmable wait/period timer. Successor to the fixed-threshold tick/toggle counter.
- Used by OLED init/refresh sequencers for power-up delays, reset pulse widths and frame-rate ticks without re-synthesis.
- Adds the following, all with a clean start/abort/done handshake:
  - loadable threshold
  - one-shot, periodic and toggle modes
  - clock prescaler
  - busy/done status
  - live count readback

Parameters:
- CNT_W, 24, width of threshold and count (max wait 2^CNT_W-1 base ticks).
- PRESCALE, 1, input clocks per base tick; legal range 1..65536; 1 means no prescaling.
- IDLE_LEVEL, 0, level of o_wave when not running (0 LOW, 1 HIGH).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_n_reset  in  1  asynchronous, active-low reset.
- i_start  in  1  start/restart request, sampled on each rising edge.
- i_abort  in  1  stop request, sampled on each rising edge; priority over i_start.
- i_mode  in  2  0 one-shot, 1 periodic, 2 toggle, 3 reserved (behaves as one-shot).
- i_threshold  in  CNT_W  wait length in base ticks; latched on an accepted start.
- o_busy  out  1  high while in RUN.
- o_tick  out  1  one-cycle pulse at each threshold expiry.
- o_done  out  1  one-cycle pulse when a one-shot wait completes.
- o_wave  out  1  toggle-mode square wave; IDLE_LEVEL when not running.
- o_count  out  CNT_W  current base-tick count.

Behaviour:
- Reset is asynchronous, active-low. While asserted:
  - state=IDLE
  - o_busy=0, o_tick=0, o_done=0, o_count=0
  - o_wave=IDLE_LEVEL
  - prescaler=0; latched mode and threshold=0
- States: IDLE, RUN. All outputs are registered.
- Prescaler pre runs 0..PRESCALE-1 in RUN only. Base enable en is (pre==PRESCALE-1). pre wraps to 0 on en.
- Accepted start (i_start=1, i_abort=0, any state):
  - latch i_threshold to thr and i_mode to mode
  - clear count and pre
  - set o_wave=IDLE_LEVEL
  - if thr!=0: enter RUN, o_busy=1 after the same edge
  - if thr==0: stay IDLE, assert o_done and o_tick for one cycle after the edge, in any mode
- In RUN on en:
  - if count!=thr-1: count++
  - if count==thr-1: count<=0 (expiry)
- Expiry (registered, visible the cycle after the edge):
  - one-shot: o_tick=1 and o_done=1 for one cycle; state->IDLE; o_busy=0 in that same cycle.
  - periodic: o_tick=1 for one cycle; stays RUN; o_done stays 0.
  - toggle: o_wave inverts and o_tick=1 for one cycle; stays RUN.
- Latency: start accepted at edge k, threshold N, prescale P → first o_tick high after edge k+N*P. Periodic repeats every N*P cycles.
- o_tick and o_done are 0 in every cycle not listed above.
- Abort (i_abort=1, any state):
  - state->IDLE; count=0, pre=0; o_busy=0
  - o_wave=IDLE_LEVEL; no o_tick or o_done pulse
  - an expiry coinciding with abort at the same edge is discarded
- Restart: an accepted start during RUN reloads thr and mode and restarts from count 0. An expiry coinciding with the restart at the same edge is discarded.
- i_threshold and i_mode changes outside an accepted start are ignored.
- Wrap: count never exceeds thr-1. thr=1 with P=1 in periodic mode gives o_tick high every cycle.
- o_count is the live count register: 0 in IDLE, 0..thr-1 in RUN.

Test Plan:
- Reset mid-RUN, CNT_W=24, P=1: start with thr=10, assert i_n_reset=0 at cycle 4 asynchronously → all outputs 0 immediately, o_wave=IDLE_LEVEL, o_busy=0, no later tick.
- One-shot, P=1: thr=5, start pulse at edge 0 → o_busy high cycles 1..5; o_tick and o_done high only after edge 5; o_busy=0 in that cycle; o_count sequence 0,0,1,2,3,4,0.
- Periodic, P=4: thr=3 → o_tick after edges 12, 24, 36; o_done never asserted; abort at edge 30 → no tick at 36, o_busy=0 after edge 30.
- Toggle, IDLE_LEVEL=1, P=1: thr=2 → o_wave 1→0 after edge 2, →1 after edge 4, →0 after edge 6; abort → o_wave=1.
- Zero threshold and contention:
  - thr=0 start → single o_done and o_tick pulse, o_busy never high.
  - i_start and i_abort together during RUN → IDLE, no pulses.
- Restart: periodic thr=8 running, start with thr=3 at count 5 → count cleared, next o_tick exactly 3 cycles later, then every 3.
